// File: rtl/riscv_pkg.sv
// Shared RISC-V branch definitions: B-type func3 encodings.
package riscv_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_func3_e;

endpackage

// File: rtl/riscv_branch_cmp.sv
// Combinational B-type condition evaluation; func3 010/011 is not a branch.
module riscv_branch_cmp
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic [2:0]      func3,
  input  logic            is_b_type,
  output logic            taken,
  output logic            valid_br
);

  logic eq, lt_s, lt_u;

  assign eq   = (opr_a == opr_b);
  assign lt_s = ($signed(opr_a) < $signed(opr_b));
  assign lt_u = (opr_a < opr_b);

  always_comb begin
    taken    = 1'b0;
    valid_br = 1'b0;
    if (is_b_type) begin
      case (func3)
        BEQ:     begin taken = eq;    valid_br = 1'b1; end
        BNE:     begin taken = !eq;   valid_br = 1'b1; end
        BLT:     begin taken = lt_s;  valid_br = 1'b1; end
        BGE:     begin taken = !lt_s; valid_br = 1'b1; end
        BLTU:    begin taken = lt_u;  valid_br = 1'b1; end
        BGEU:    begin taken = !lt_u; valid_br = 1'b1; end
        default: begin taken = 1'b0;  valid_br = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// Branch resolve unit with a saturating-counter direction table indexed by PC or gshare hash,
// a non-speculative global history and a registered mispredict redirect.
module riscv_branch_predictor
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CTR_W       = 2,
  parameter int unsigned GSHARE      = 0,
  parameter int unsigned GHR_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_taken_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             res_valid_i,
  input  logic [XLEN-1:0]  res_pc_i,
  input  logic [GHR_W-1:0] res_ghr_i,
  input  logic             res_pred_taken_i,
  input  logic [XLEN-1:0]  opr_a_i,
  input  logic [XLEN-1:0]  opr_b_i,
  input  logic             is_b_type_ctl_i,
  input  logic [2:0]       instr_func3_ctl_i,
  input  logic [XLEN-1:0]  res_target_i,
  input  logic [XLEN-1:0]  res_next_pc_i,
  output logic             branch_taken_o,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [31:0]      br_cnt_o,
  output logic [31:0]      mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  // Weakly not-taken; evaluates to 0 when CTR_W is 1.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [CTR_W-1:0] bht_q [BHT_ENTRIES];
  logic [GHR_W-1:0] ghr_q;
  logic             mispredict_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [31:0]      br_cnt_q, mispred_cnt_q;

  logic             taken, valid_br, upd, mispred;
  logic [IDX_W-1:0] pred_idx, res_idx;
  logic [CTR_W-1:0] res_ctr;
  logic             unused_pc;

  function automatic logic [IDX_W-1:0] bht_index(input logic [XLEN-1:0]  pc,
                                                 input logic [GHR_W-1:0] hist);
    logic [IDX_W-1:0] idx;
    idx = pc[IDX_W+1:2];
    if (GSHARE != 0) idx[GHR_W-1:0] = idx[GHR_W-1:0] ^ hist;
    return idx;
  endfunction

  riscv_branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .opr_a    (opr_a_i),
    .opr_b    (opr_b_i),
    .func3    (instr_func3_ctl_i),
    .is_b_type(is_b_type_ctl_i),
    .taken    (taken),
    .valid_br (valid_br)
  );

  assign pred_idx = bht_index(pred_pc_i, ghr_q);
  assign res_idx  = bht_index(res_pc_i, res_ghr_i);
  assign res_ctr  = bht_q[res_idx];
  assign upd      = res_valid_i & valid_br;
  assign mispred  = res_valid_i & (taken != res_pred_taken_i);

  assign pred_taken_o   = bht_q[pred_idx][CTR_W-1];
  assign pred_ghr_o     = ghr_q;
  assign branch_taken_o = taken;
  assign mispredict_o   = mispredict_q;
  assign redirect_pc_o  = redirect_pc_q;
  assign br_cnt_o       = br_cnt_q;
  assign mispred_cnt_o  = mispred_cnt_q;

  assign unused_pc = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0],
                       res_pc_i[XLEN-1:IDX_W+2], res_pc_i[1:0]};

  // Lookups read the pre-update table and history; there is no bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
      ghr_q <= '0;
    end else if (upd) begin
      if (taken && (res_ctr != '1)) begin
        bht_q[res_idx] <= res_ctr + 1'b1;
      end else if (!taken && (res_ctr != '0)) begin
        bht_q[res_idx] <= res_ctr - 1'b1;
      end
      ghr_q <= GHR_W'({ghr_q, taken});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q <= mispred;
      if (mispred) redirect_pc_q <= taken ? res_target_i : res_next_pc_i;
      if (upd && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
      // Non-branches and invalid func3 still redirect but are not counted as branch mispredicts.
      if (mispred && valid_br && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Bench: a PC-indexed and a gshare instance share stimulus; a per-cycle model check plus
// directed literal expectations.
module tb_riscv_branch_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pred_pc = '0, res_pc = '0, opr_a = '0, opr_b = '0;
  logic [31:0] res_target = '0, res_next_pc = '0;
  logic [5:0]  res_ghr0 = '0;
  logic [1:0]  res_ghr1 = '0;
  logic        res_valid = 1'b0, res_pred_taken = 1'b0, is_b_type = 1'b0;
  logic [2:0]  func3 = '0;

  logic        pt0, pt1, bt0, bt1, mis0, mis1;
  logic [5:0]  ghr0;
  logic [1:0]  ghr1;
  logic [31:0] red0, red1, brc0, brc1, mc0, mc1;

  logic        pt_w [2];
  logic        bt_w [2];
  logic        mis_w [2];
  logic [31:0] ghr_w [2];
  logic [31:0] red_w [2];
  logic [31:0] brc_w [2];
  logic [31:0] mc_w [2];

  int checks = 0;
  int errors = 0;

  int          m_ctr [2][64];
  int          m_ghr [2];
  bit          m_mis;
  logic [31:0] m_red;
  longint      m_br, m_mc;

  logic [2:0] cmp_f3 [8] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
  logic       cmp_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       train_mis [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  riscv_branch_predictor #(
    .XLEN(32), .BHT_ENTRIES(64), .CTR_W(2), .GSHARE(0), .GHR_W(6)
  ) u_dut (
    .clk(clk), .reset(reset), .pred_pc_i(pred_pc), .pred_taken_o(pt0), .pred_ghr_o(ghr0),
    .res_valid_i(res_valid), .res_pc_i(res_pc), .res_ghr_i(res_ghr0),
    .res_pred_taken_i(res_pred_taken), .opr_a_i(opr_a), .opr_b_i(opr_b),
    .is_b_type_ctl_i(is_b_type), .instr_func3_ctl_i(func3), .res_target_i(res_target),
    .res_next_pc_i(res_next_pc), .branch_taken_o(bt0), .mispredict_o(mis0),
    .redirect_pc_o(red0), .br_cnt_o(brc0), .mispred_cnt_o(mc0)
  );

  riscv_branch_predictor #(
    .XLEN(32), .BHT_ENTRIES(64), .CTR_W(2), .GSHARE(1), .GHR_W(2)
  ) u_gs (
    .clk(clk), .reset(reset), .pred_pc_i(pred_pc), .pred_taken_o(pt1), .pred_ghr_o(ghr1),
    .res_valid_i(res_valid), .res_pc_i(res_pc), .res_ghr_i(res_ghr1),
    .res_pred_taken_i(res_pred_taken), .opr_a_i(opr_a), .opr_b_i(opr_b),
    .is_b_type_ctl_i(is_b_type), .instr_func3_ctl_i(func3), .res_target_i(res_target),
    .res_next_pc_i(res_next_pc), .branch_taken_o(bt1), .mispredict_o(mis1),
    .redirect_pc_o(red1), .br_cnt_o(brc1), .mispred_cnt_o(mc1)
  );

  assign pt_w[0] = pt0;   assign pt_w[1] = pt1;
  assign bt_w[0] = bt0;   assign bt_w[1] = bt1;
  assign mis_w[0] = mis0; assign mis_w[1] = mis1;
  assign ghr_w[0] = 32'(ghr0); assign ghr_w[1] = 32'(ghr1);
  assign red_w[0] = red0; assign red_w[1] = red1;
  assign brc_w[0] = brc0; assign brc_w[1] = brc1;
  assign mc_w[0] = mc0;   assign mc_w[1] = mc1;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instance 0 indexes by PC word bits; instance 1 XORs the 2-bit history into the index.
  function automatic int idx_of(input int d, input logic [31:0] pc, input int hist);
    int i;
    i = int'((pc / 4) % 64);
    if (d == 1) i = i ^ (hist % 4);
    return i;
  endfunction

  function automatic void outcome(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] f3, input logic isb,
                                  output bit tk, output bit vb);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    tk = 1'b0;
    vb = isb && (f3 != 3'd2) && (f3 != 3'd3);
    if (vb) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = (sa < sb);
        3'd5: tk = (sa >= sb);
        3'd6: tk = (a < b);
        3'd7: tk = (a >= b);
        default: tk = 1'b0;
      endcase
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) m_ctr[d][i] = 1;
      m_ghr[d] = 0;
    end
    m_mis = 1'b0;
    m_red = '0;
    m_br  = 0;
    m_mc  = 0;
  endtask

  initial begin : model_proc
    bit          tk, vb, mis, upd;
    int          ri [2];
    logic [31:0] red_n;
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      outcome(opr_a, opr_b, func3, is_b_type, tk, vb);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pred_taken[%0d]", d), 64'(pt_w[d]),
            64'(m_ctr[d][idx_of(d, pred_pc, m_ghr[d])] >= 2));
        chk($sformatf("pred_ghr[%0d]", d), 64'(ghr_w[d]), 64'(m_ghr[d]));
        chk($sformatf("branch_taken[%0d]", d), 64'(bt_w[d]), 64'(tk));
        chk($sformatf("mispredict[%0d]", d), 64'(mis_w[d]), 64'(m_mis));
        if (m_mis) chk($sformatf("redirect_pc[%0d]", d), 64'(red_w[d]), 64'(m_red));
        chk($sformatf("br_cnt[%0d]", d), 64'(brc_w[d]), 64'(m_br));
        chk($sformatf("mispred_cnt[%0d]", d), 64'(mc_w[d]), 64'(m_mc));
      end
      upd   = res_valid && vb;
      mis   = res_valid && (tk != res_pred_taken);
      red_n = tk ? res_target : res_next_pc;
      ri[0] = idx_of(0, res_pc, int'(res_ghr0));
      ri[1] = idx_of(1, res_pc, int'(res_ghr1));
      @(posedge clk);
      if (reset) begin
        model_reset();
      end else begin
        if (upd) begin
          for (int d = 0; d < 2; d++) begin
            if (tk) m_ctr[d][ri[d]] = (m_ctr[d][ri[d]] < 3) ? m_ctr[d][ri[d]] + 1 : 3;
            else    m_ctr[d][ri[d]] = (m_ctr[d][ri[d]] > 0) ? m_ctr[d][ri[d]] - 1 : 0;
            m_ghr[d] = (m_ghr[d] * 2 + int'(tk)) % ((d == 0) ? 64 : 4);
          end
          if (m_br < 64'hFFFF_FFFF) m_br++;
        end
        if (mis && vb && (m_mc < 64'hFFFF_FFFF)) m_mc++;
        m_mis = mis;
        if (mis) m_red = red_n;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res_valid      = 1'b0;
    is_b_type      = 1'b0;
    res_pred_taken = 1'b0;
    func3          = 3'd0;
    opr_a          = '0;
    opr_b          = '0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic isb, input logic pred,
                         input logic [31:0] tgt, input logic [31:0] nxt);
    res_valid      = 1'b1;
    res_pc         = pc;
    opr_a          = a;
    opr_b          = b;
    func3          = f3;
    is_b_type      = isb;
    res_pred_taken = pred;
    res_target     = tgt;
    res_next_pc    = nxt;
    res_ghr0       = 6'(m_ghr[0]);
    res_ghr1       = 2'(m_ghr[1]);
    step();
    idle();
  endtask

  initial begin : stim
    bit tk;
    bit p;
    idle();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    step();
    chk("reset mispredict", 64'(mis0), 64'd0);
    chk("reset br_cnt", 64'(brc0), 64'd0);
    chk("reset pred_taken", 64'(pt0), 64'd0);

    // Signed vs unsigned: a = -1 / 0xFFFF_FFFF, b = 1.
    for (int i = 0; i < 8; i++) begin
      step();
      opr_a     = 32'hFFFF_FFFF;
      opr_b     = 32'd1;
      is_b_type = 1'b1;
      func3     = cmp_f3[i];
      #1;
      chk($sformatf("cmp func3=%0d", cmp_f3[i]), 64'(bt0), 64'(cmp_exp[i]));
    end
    step();
    is_b_type = 1'b0;
    func3     = 3'd1;
    #1 chk("cmp non-branch", 64'(bt0), 64'd0);
    step();
    idle();
    pred_pc = 32'h100;
    step();

    // Training: first two resolves were fetched before the table learned anything.
    for (int i = 0; i < 4; i++) begin
      resolve(32'h100, 32'd5, 32'd5, 3'd0, 1'b1, (i >= 2), 32'h200, 32'h104);
      chk($sformatf("train mispredict %0d", i), 64'(mis0), 64'(train_mis[i]));
    end
    chk("train br_cnt", 64'(brc0), 64'd4);
    chk("train mispred_cnt", 64'(mc0), 64'd2);
    chk("train pred_taken", 64'(pt0), 64'd1);
    resolve(32'h100, 32'd0, 32'd1, 3'd0, 1'b1, 1'b1, 32'h200, 32'h104);
    chk("untrain1 mispredict", 64'(mis0), 64'd1);
    chk("untrain1 pred_taken", 64'(pt0), 64'd1);
    resolve(32'h100, 32'd0, 32'd1, 3'd0, 1'b1, 1'b1, 32'h200, 32'h104);
    chk("untrain2 mispredict", 64'(mis0), 64'd1);
    chk("untrain2 pred_taken", 64'(pt0), 64'd0);
    chk("untrain br_cnt", 64'(brc0), 64'd6);
    chk("untrain mispred_cnt", 64'(mc0), 64'd4);

    resolve(32'h104, 32'd7, 32'd7, 3'd1, 1'b1, 1'b1, 32'h200, 32'h104);
    chk("redirect mispredict", 64'(mis0), 64'd1);
    chk("redirect pc", 64'(red0), 64'h104);
    chk("redirect br_cnt", 64'(brc0), 64'd7);
    step();
    chk("redirect pulse end", 64'(mis0), 64'd0);

    resolve(32'h108, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 32'h400, 32'h10C);
    chk("nonbranch mispredict", 64'(mis0), 64'd1);
    chk("nonbranch redirect", 64'(red0), 64'h10C);
    chk("nonbranch br_cnt", 64'(brc0), 64'd7);
    chk("nonbranch mispred_cnt", 64'(mc0), 64'd5);
    resolve(32'h10C, 32'd3, 32'd3, 3'd2, 1'b1, 1'b1, 32'h500, 32'h110);
    chk("badf3 mispredict", 64'(mis0), 64'd1);
    chk("badf3 redirect", 64'(red0), 64'h110);
    chk("badf3 br_cnt", 64'(brc0), 64'd7);
    chk("badf3 mispred_cnt", 64'(mc0), 64'd5);

    // Alternating T/N at one PC: gshare instance must learn it from history.
    pred_pc = 32'h180;
    step();
    for (int i = 0; i < 16; i++) begin
      tk = (i % 2 == 0);
      p  = (m_ctr[1][idx_of(1, 32'h180, m_ghr[1])] >= 2);
      if (i >= 8) chk($sformatf("gshare pred %0d", i), 64'(pt1), 64'(tk));
      resolve(32'h180, 32'd5, tk ? 32'd5 : 32'd6, 3'd0, 1'b1, p, 32'h300, 32'h184);
      if (i >= 8) chk($sformatf("gshare mispredict %0d", i), 64'(mis1), 64'd0);
    end

    // Asynchronous reset in the middle of a pending update.
    pred_pc = 32'h100;
    step();
    resolve(32'h100, 32'd5, 32'd5, 3'd0, 1'b1, 1'b0, 32'h200, 32'h104);
    chk("pre-reset mispredict", 64'(mis0), 64'd1);
    chk("pre-reset pred_taken", 64'(pt0), 64'd1);
    res_valid = 1'b1;
    res_pc    = 32'h100;
    opr_a     = 32'd5;
    opr_b     = 32'd5;
    is_b_type = 1'b1;
    func3     = 3'd0;
    #1 reset = 1'b1;
    #1;
    chk("async mispredict", 64'(mis0), 64'd0);
    chk("async redirect", 64'(red0), 64'd0);
    chk("async br_cnt", 64'(brc0), 64'd0);
    chk("async mispred_cnt", 64'(mc0), 64'd0);
    chk("async ghr gshare", 64'(ghr1), 64'd0);
    chk("async pred_taken", 64'(pt0), 64'd0);
    step();
    chk("held br_cnt", 64'(brc0), 64'd0);
    chk("held mispredict", 64'(mis0), 64'd0);
    idle();
    #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      pred_pc = 32'(i * 4);
      #1;
      chk($sformatf("post-reset pred pc=%0h", i * 4), 64'({pt0, pt1}), 64'd0);
    end
    chk("post-reset br_cnt", 64'(brc0), 64'd0);
    chk("post-reset mispred_cnt", 64'(mc0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
